lock_code_writer: RTL and testbench

Programming end of the 2-bit combination lock: owns the stored code `v1:v0` that the lock checker compares user entries against. Lets the user replace the code through an authenticated three-step sequence: old code, new code, then new code again. Gates the checker's enable `e` while programming is in progress. Drives three status lights `x`, `y`, `z` and enforces a lockout after repeated failures.

---
 rtl/lock_code_writer.sv | 158 +++++++++++++++
 tb/tb_lock_code_writer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lock_code_writer.sv
// Programming side of the 2-bit combination lock.
// Holds the stored code, runs the old/new/confirm change sequence and drives the status lights.
module lock_code_writer #(
    parameter int         HOLD_CYCLES    = 4,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCK_CYCLES    = 32,
    parameter logic [1:0] DEFAULT_CODE   = 2'b00
) (
    input  logic clk,
    input  logic rst_n,
    input  logic prog,
    input  logic ok,
    input  logic b1,
    input  logic b0,
    output logic v1,
    output logic v0,
    output logic e,
    output logic x,
    output logic y,
    output logic z
);

    localparam int MAX_HT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_T  = (MAX_HT > LOCK_CYCLES) ? MAX_HT : LOCK_CYCLES;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYCLES - 1);
    localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE,
        AUTH,
        NEW1,
        NEW2,
        DONE,
        FAIL,
        LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    code_q, code_d;
    logic [1:0]    tmp_q, tmp_d;
    logic [1:0]    fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] t_q, t_d;
    logic          prog_q, prog_d;
    logic          ok_q, ok_d;

    logic       prog_ev;
    logic       ok_ev;
    logic [1:0] sw;
    logic [1:0] fail_inc;

    assign prog_ev  = prog & ~prog_q;
    assign ok_ev    = ok & ~ok_q;
    assign sw       = {b1, b0};
    assign fail_inc = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= DEFAULT_CODE;
            tmp_q      <= 2'b00;
            fail_cnt_q <= 2'b00;
            t_q        <= '0;
            prog_q     <= 1'b1;
            ok_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            tmp_q      <= tmp_d;
            fail_cnt_q <= fail_cnt_d;
            t_q        <= t_d;
            prog_q     <= prog_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        tmp_d      = tmp_q;
        fail_cnt_d = fail_cnt_q;
        t_d        = t_q + TW'(1);
        prog_d     = prog;
        ok_d       = ok;

        case (state_q)
            IDLE: begin
                t_d = '0;
                if (prog_ev) state_d = AUTH;
            end
            AUTH, NEW1, NEW2: begin
                // cancel wins over a same-cycle confirm
                if (prog_ev) begin
                    state_d = IDLE;
                end else if (ok_ev) begin
                    t_d = '0;
                    if (state_q == AUTH) begin
                        if (sw == code_q) begin
                            state_d = NEW1;
                        end else begin
                            state_d    = FAIL;
                            fail_cnt_d = fail_inc;
                        end
                    end else if (state_q == NEW1) begin
                        tmp_d   = sw;
                        state_d = NEW2;
                    end else if (sw == tmp_q) begin
                        code_d     = tmp_q;
                        fail_cnt_d = 2'd0;
                        state_d    = DONE;
                    end else begin
                        state_d    = FAIL;
                        fail_cnt_d = fail_inc;
                    end
                end else if (t_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (t_q == HOLD_LAST) state_d = IDLE;
            end
            FAIL: begin
                if (t_q == HOLD_LAST) state_d = (fail_cnt_q >= FAIL_LIMIT) ? LOCK : IDLE;
            end
            LOCK: begin
                if (t_q == LOCK_LAST) begin
                    state_d    = IDLE;
                    fail_cnt_d = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) t_d = '0;
    end

    always_comb begin
        {e, x, y, z} = 4'b1000;
        case (state_q)
            IDLE:    {e, x, y, z} = 4'b1000;
            AUTH:    {e, x, y, z} = 4'b0001;
            NEW1:    {e, x, y, z} = 4'b0011;
            NEW2:    {e, x, y, z} = 4'b0011;
            DONE:    {e, x, y, z} = 4'b0010;
            FAIL:    {e, x, y, z} = 4'b0100;
            LOCK:    {e, x, y, z} = 4'b0101;
            default: {e, x, y, z} = 4'b1000;
        endcase
    end

    assign v1 = code_q[1];
    assign v0 = code_q[0];

endmodule

// File: tb/tb_lock_code_writer.sv
// Directed bench for lock_code_writer: expected {e,x,y,z,v1,v0} per cycle goes through a scoreboard queue.
module tb_lock_code_writer;

    localparam logic [3:0] S_IDLE = 4'b1000;
    localparam logic [3:0] S_AUTH = 4'b0001;
    localparam logic [3:0] S_NEW  = 4'b0011;
    localparam logic [3:0] S_DONE = 4'b0010;
    localparam logic [3:0] S_FAIL = 4'b0100;
    localparam logic [3:0] S_LOCK = 4'b0101;

    logic clk = 1'b0;
    logic rst_n, prog, ok, b1, b0;
    logic v1, v0, e, x, y, z;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] code;
    int         n_eval = 0;
    int         n_fail = 0;

    lock_code_writer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .prog (prog),
        .ok   (ok),
        .b1   (b1),
        .b0   (b0),
        .v1   (v1),
        .v0   (v0),
        .e    (e),
        .x    (x),
        .y    (y),
        .z    (z)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic p, input logic o, input logic [1:0] b);
        rst_n = r;
        prog  = p;
        ok    = o;
        {b1, b0} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t       item;
        logic [5:0] obs;
        obs = {e, x, y, z, v1, v0};
        n_eval++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("[TB] FAIL scoreboard_empty observed=%b", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp)
            else begin
                n_fail++;
                $error("[TB] FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic step(input string tag, input logic p, input logic o, input logic [1:0] b,
                        input logic [3:0] st);
        sb.push_back('{tag: tag, exp: {st, code}});
        applyStimulus(1'b1, p, o, b);
        checkOutput();
    endtask

    task automatic stepRst(input string tag, input logic p, input logic o);
        code = 2'b00;
        sb.push_back('{tag: tag, exp: {S_IDLE, code}});
        applyStimulus(1'b0, p, o, 2'b00);
        checkOutput();
    endtask

    task automatic holdFail(input string tag, input logic [3:0] after);
        for (int i = 0; i < 3; i++) step(tag, 1'b0, 1'b0, 2'b00, S_FAIL);
        step({tag, "_exit"}, 1'b0, 1'b0, 2'b00, after);
    endtask

    task automatic wrongOld(input string tag, input logic [3:0] after);
        step({tag, "_auth"}, 1'b1, 1'b0, 2'b00, S_AUTH);
        step({tag, "_auth_rel"}, 1'b0, 1'b0, 2'b00, S_AUTH);
        step({tag, "_fail"}, 1'b0, 1'b1, 2'b01, S_FAIL);
        holdFail({tag, "_fail_hold"}, after);
    endtask

    initial begin
        code = 2'b00;

        stepRst("rst_held_0", 1'b1, 1'b1);
        stepRst("rst_held_1", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("held_after_rst", 1'b1, 1'b1, 2'b00, S_IDLE);
        step("held_release", 1'b0, 1'b0, 2'b00, S_IDLE);

        step("chg_auth", 1'b1, 1'b0, 2'b00, S_AUTH);
        step("chg_auth_rel", 1'b0, 1'b0, 2'b00, S_AUTH);
        step("chg_new1", 1'b0, 1'b1, 2'b00, S_NEW);
        step("chg_new1_rel", 1'b0, 1'b0, 2'b10, S_NEW);
        step("chg_new2", 1'b0, 1'b1, 2'b10, S_NEW);
        step("chg_new2_rel", 1'b0, 1'b0, 2'b10, S_NEW);
        code = 2'b10;
        step("chg_done", 1'b0, 1'b1, 2'b10, S_DONE);
        step("chg_done_1", 1'b0, 1'b0, 2'b10, S_DONE);
        step("chg_done_ok_ignored", 1'b0, 1'b1, 2'b10, S_DONE);
        step("chg_done_3", 1'b0, 1'b0, 2'b10, S_DONE);
        step("chg_done_exit", 1'b0, 1'b0, 2'b10, S_IDLE);

        wrongOld("wrong1", S_IDLE);
        wrongOld("wrong2", S_IDLE);

        step("w3_auth", 1'b1, 1'b0, 2'b00, S_AUTH);
        step("w3_auth_rel", 1'b0, 1'b0, 2'b00, S_AUTH);
        step("w3_new1", 1'b0, 1'b1, 2'b10, S_NEW);
        step("w3_new1_rel", 1'b0, 1'b0, 2'b11, S_NEW);
        step("w3_new2", 1'b0, 1'b1, 2'b11, S_NEW);
        step("w3_new2_rel", 1'b0, 1'b0, 2'b01, S_NEW);
        step("w3_fail", 1'b0, 1'b1, 2'b01, S_FAIL);
        holdFail("w3_fail_hold", S_LOCK);
        for (int i = 0; i < 31; i++)
            step("lock_hold", (i % 4) == 1, (i % 4) == 3, 2'b10, S_LOCK);
        step("lock_exit", 1'b0, 1'b0, 2'b00, S_IDLE);

        wrongOld("post_lock", S_IDLE);

        step("to_auth", 1'b1, 1'b0, 2'b00, S_AUTH);
        for (int i = 0; i < 15; i++) step("to_wait", 1'b0, 1'b0, 2'b00, S_AUTH);
        step("to_abort", 1'b0, 1'b0, 2'b00, S_IDLE);

        step("cx_auth", 1'b1, 1'b0, 2'b00, S_AUTH);
        step("cx_auth_rel", 1'b0, 1'b0, 2'b10, S_AUTH);
        step("cx_new1", 1'b0, 1'b1, 2'b10, S_NEW);
        step("cx_new1_rel", 1'b0, 1'b0, 2'b01, S_NEW);
        step("cx_new2", 1'b0, 1'b1, 2'b01, S_NEW);
        step("cx_new2_rel", 1'b0, 1'b0, 2'b01, S_NEW);
        step("cx_cancel", 1'b1, 1'b1, 2'b01, S_IDLE);
        step("cx_idle", 1'b0, 1'b0, 2'b01, S_IDLE);

        wrongOld("after_to_cx", S_IDLE);

        step("mr_auth", 1'b1, 1'b0, 2'b00, S_AUTH);
        step("mr_auth_rel", 1'b0, 1'b0, 2'b10, S_AUTH);
        step("mr_new1", 1'b0, 1'b1, 2'b10, S_NEW);
        step("mr_new1_rel", 1'b0, 1'b0, 2'b11, S_NEW);
        step("mr_new2", 1'b0, 1'b1, 2'b11, S_NEW);
        step("mr_new2_rel", 1'b0, 1'b0, 2'b11, S_NEW);
        stepRst("mr_reset", 1'b0, 1'b0);
        step("mr_idle", 1'b0, 1'b0, 2'b11, S_IDLE);

        if (sb.size() != 0) begin
            n_eval++;
            n_fail++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
